serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 144 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller built around one 1-bit full adder
// Optional ovf output (signed overflow) is enabled by defining SERIAL_ADD_CTRL_OVF_EN.

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_CTRL_OVF_EN
  output logic             ovf,
`endif
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic             cmsb_q, cmsb_d, ovf_q, ovf_d;
`endif

  FullAdder u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    cmsb_d  = cmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef SERIAL_ADD_CTRL_OVF_EN
          cmsb_d  = carry_q;
`endif
        end
      end
      DONE: begin
        s_d     = psum_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
`ifdef SERIAL_ADD_CTRL_OVF_EN
        ovf_d   = cmsb_q ^ carry_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=4)
// Covers ovf when built with SERIAL_ADD_CTRL_OVF_EN.

module tb_serial_add_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, Cin;
  logic [W-1:0] A, B;
  logic         busy, done, Cout;
  logic [W-1:0] S;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] prev_s;
  logic         prev_c, prev_o;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
`ifdef SERIAL_ADD_CTRL_OVF_EN
    .ovf   (ovf),
`endif
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unsigned sum for S/Cout, signed range test for overflow.
  function automatic void model(input int a, input int b, input int c,
                                output logic [W-1:0] s, output logic co, output logic ov);
    int sum, sa, sb, sr;
    sum = a + b + c;
    s   = W'(sum % (1 << W));
    co  = (sum >= (1 << W));
    sa  = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb  = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sr  = sa + sb + c;
    ov  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_sum"}, 32'(S), 32'(es));
    check({tag, "_cout"}, 32'(Cout), 32'(ec));
`ifdef SERIAL_ADD_CTRL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) check({tag, "_ovf_model"}, 32'(eo), 32'd0);
`endif
  endtask

  // Called at a negedge while idle; returns at the negedge of the done cycle.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    logic got;
    start = 1'b1; A = a; B = b; Cin = cin;
    @(posedge clk);
    got = 1'b0;
    for (int j = 0; j < 12 && !got; j++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check("latency", 32'(j), 32'(W + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        check_result("add", es, ec, eo);
      end else begin
        check("busy_run", 32'(busy), 32'd1);
        check("s_hold", 32'(S), 32'(prev_s));
        check("cout_hold", 32'(Cout), 32'(prev_c));
        start = 1'($urandom);
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    start = 1'b0;
    prev_s = es; prev_c = ec; prev_o = eo;
  endtask

  task automatic do_model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W-1:0] s; logic c, o;
    model(int'(a), int'(b), int'(cin), s, c, o);
    do_add(a, b, cin, s, c, o);
  endtask

  initial begin
    logic [W+W:0] op[30];
    logic [W-1:0] es;
    logic ec, eo;
    int pulses;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  cin: 1'b0, s: 4'd8,  c: 1'b0, o: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  cin: 1'b0, s: 4'd0,  c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, c: 1'b1, o: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, s: 4'd0,  c: 1'b0, o: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd8,  cin: 1'b1, s: 4'd0,  c: 1'b1, o: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd6,  cin: 1'b0, s: 4'd15, c: 1'b0, o: 1'b0};
    vecs[6] = '{a: 4'd7,  b: 4'd7,  cin: 1'b1, s: 4'd15, c: 1'b0, o: 1'b1};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, s: 4'd0,  c: 1'b1, o: 1'b1};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    prev_s = '0; prev_c = 1'b0; prev_o = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          do_model_add(W'(a), W'(b), 1'(c));

    for (int i = 0; i < 100; i++)
      do_model_add(W'($urandom), W'($urandom), 1'($urandom));

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 30; i++) begin
      start = 1'b1;
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      op[i] = {A, B, Cin};
      @(negedge clk);
      check("stream_done", 32'(done), 32'((i % (W + 2)) == W + 1));
      if ((i % (W + 2)) == W + 1) begin
        model(int'(op[i-W-1][2*W:W+1]), int'(op[i-W-1][W:1]), int'(op[i-W-1][0]), es, ec, eo);
        check_result("stream", es, ec, eo);
        prev_s = es; prev_c = ec; prev_o = eo;
      end
    end
    start = 1'b0;

    do_model_add(4'd3, 4'd5, 1'b0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; A = 4'd9; B = 4'd9; Cin = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check_result("midrst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    prev_s = '0; prev_c = 1'b0; prev_o = 1'b0;
    do_model_add(4'd12, 4'd6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
